// File: rtl/link_reload_tx.sv
// Transmit end of the inter-board reload line.
// Turns local reload requests into framed low pulses on a wire that idles
// high ("connected"). Each pulse is held low for PULSE_CYCLES and is always
// followed by GUARD_CYCLES of high, so the partner's edge detector never
// misses or merges events. One request can wait behind the current event;
// further requests are counted as drops.
module link_reload_tx #(
   parameter int unsigned PULSE_CYCLES = 650000,
   parameter int unsigned GUARD_CYCLES = 650000,
   parameter int unsigned CNT_WIDTH    = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       req,
   output logic       link_out,
   output logic       busy,
   output logic       pending,
   output logic       sent,
   output logic [7:0] drop_count
);

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      GUARD    = 2'd1,
      IDLE     = 2'd2,
      PULSE    = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] PULSE_LAST = CNT_WIDTH'(PULSE_CYCLES - 32'd1);
   localparam logic [CNT_WIDTH-1:0] GUARD_LAST = CNT_WIDTH'(GUARD_CYCLES - 32'd1);

   // Saturating increment for the drop counter; it sticks at 255 instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      logic [7:0] result;
      if (value != 8'hFF) begin
         result = value + 8'd1;
      end else begin
         result = value;
      end
      return result;
   endfunction

   state_t               state_r, state_s;
   logic [CNT_WIDTH-1:0] cnt_r, cnt_s;
   logic                 link_r, link_s;
   logic                 busy_r, busy_s;
   logic                 pending_r, pending_s;
   logic                 sent_r, sent_s;
   logic [7:0]           drop_r, drop_s;
   logic                 queue_slot_s;

   // A request arriving while an event is in flight (any PULSE cycle, or a
   // GUARD cycle that is not the last) goes to the one-deep queue or is dropped.
   // In the last GUARD cycle the request is consumed directly instead.
   always_comb begin
      queue_slot_s = 1'b0;
      case (state_r)
         PULSE:    queue_slot_s = 1'b1;
         GUARD:    queue_slot_s = (cnt_r != GUARD_LAST);
         default:  queue_slot_s = 1'b0;
      endcase
   end

   // Next-state and next-output logic; disable overrides everything else.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      link_s    = link_r;
      pending_s = pending_r;
      sent_s    = 1'b0;
      drop_s    = drop_r;

      if (!enable) begin
         state_s   = DISABLED;
         cnt_s     = CNT_ZERO;
         link_s    = 1'b0;
         pending_s = 1'b0;
      end else begin
         if (queue_slot_s && req) begin
            if (!pending_r) begin
               pending_s = 1'b1;
            end else begin
               drop_s = sat_inc(drop_r);
            end
         end else begin
            pending_s = pending_r;
         end

         case (state_r)
            DISABLED: begin
               state_s = GUARD;
               cnt_s   = CNT_ZERO;
               link_s  = 1'b1;
            end
            GUARD: begin
               link_s = 1'b1;
               if (cnt_r == GUARD_LAST) begin
                  cnt_s = CNT_ZERO;
                  if (pending_r || req) begin
                     state_s   = PULSE;
                     link_s    = 1'b0;
                     pending_s = 1'b0;
                  end else begin
                     state_s = IDLE;
                  end
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            IDLE: begin
               link_s = 1'b1;
               if (req) begin
                  state_s = PULSE;
                  cnt_s   = CNT_ZERO;
                  link_s  = 1'b0;
               end else begin
                  state_s = IDLE;
               end
            end
            PULSE: begin
               link_s = 1'b0;
               if (cnt_r == PULSE_LAST) begin
                  state_s = GUARD;
                  cnt_s   = CNT_ZERO;
                  link_s  = 1'b1;
                  sent_s  = 1'b1;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            default: begin
               state_s   = DISABLED;
               cnt_s     = CNT_ZERO;
               link_s    = 1'b0;
               pending_s = 1'b0;
            end
         endcase
      end

      busy_s = (state_s != IDLE);
   end

   // State, counter and all outputs are registered; reset drives the line low at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= DISABLED;
         cnt_r     <= CNT_ZERO;
         link_r    <= 1'b0;
         busy_r    <= 1'b1;
         pending_r <= 1'b0;
         sent_r    <= 1'b0;
         drop_r    <= 8'd0;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         link_r    <= link_s;
         busy_r    <= busy_s;
         pending_r <= pending_s;
         sent_r    <= sent_s;
         drop_r    <= drop_s;
      end
   end

   assign link_out   = link_r;
   assign busy       = busy_r;
   assign pending    = pending_r;
   assign sent       = sent_r;
   assign drop_count = drop_r;

endmodule

// File: tb/tb_link_reload_tx.sv
// Self-checking bench for link_reload_tx with PULSE_CYCLES=4, GUARD_CYCLES=3.
// Expected outputs are pushed to a scoreboard queue as each input cycle is
// driven and popped when the DUT has produced the registered result.
module tb_link_reload_tx;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       req;
   logic       link_out;
   logic       busy;
   logic       pending;
   logic       sent;
   logic [7:0] drop_count;

   typedef struct packed {
      logic       link;
      logic       snt;
      logic       bsy;
      logic       pnd;
      logic [7:0] drp;
   } exp_t;

   exp_t sb_q[$];
   int   err_cnt;
   int   chk_cnt;
   int   step_no;

   link_reload_tx #(
      .PULSE_CYCLES(4),
      .GUARD_CYCLES(3),
      .CNT_WIDTH(20)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .req(req),
      .link_out(link_out),
      .busy(busy),
      .pending(pending),
      .sent(sent),
      .drop_count(drop_count)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s (step %0d): got %0d expected %0d", tag, step_no, got, exp);
      end
   endtask

   // Drive one input cycle, pushing what the outputs must look like after the edge.
   task automatic cyc(input logic en, input logic rq,
                      input logic e_link, input logic e_sent, input logic e_busy,
                      input logic e_pend, input logic [7:0] e_drop);
      exp_t e;
      e.link = e_link;
      e.snt  = e_sent;
      e.bsy  = e_busy;
      e.pnd  = e_pend;
      e.drp  = e_drop;
      sb_q.push_back(e);
      enable = en;
      req    = rq;
      @(posedge clk);
      @(negedge clk);
      step_no++;
      if (sb_q.size() == 0) begin
         check_val("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check_val("link_out", 32'(link_out), 32'(e.link));
         check_val("sent", 32'(sent), 32'(e.snt));
         check_val("busy", 32'(busy), 32'(e.bsy));
         check_val("pending", 32'(pending), 32'(e.pnd));
         check_val("drop_count", 32'(drop_count), 32'(e.drp));
      end
   endtask

   function automatic logic [7:0] sat(input logic [7:0] v);
      return (v == 8'd255) ? 8'd255 : v + 8'd1;
   endfunction

   initial begin
      logic [7:0] d;
      int         ph;
      err_cnt = 0;
      chk_cnt = 0;
      step_no = 0;
      enable  = 1'b1;
      req     = 1'b0;
      rst_n   = 1'b1;
      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("rst_link", 32'(link_out), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd1);
      check_val("rst_pending", 32'(pending), 32'd0);
      check_val("rst_sent", 32'(sent), 32'd0);
      check_val("rst_drop", 32'(drop_count), 32'd0);
      rst_n = 1'b1;

      // 1: power-up guard, then idle.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

      // 2: single request from idle.
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

      // 3: three strobes during one pulse: one queued, two dropped.
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2);
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd2);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2);
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);

      // 4: req held high: 4 low / 3 high, five drops per period, saturating at 255.
      d = 8'd2;
      for (int k = 1; k <= 420; k++) begin
         ph = (k - 1) % 7;
         case (ph)
            0: cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, d);
            1: cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, d);
            2, 3: begin
               d = sat(d);
               cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, d);
            end
            4: begin
               d = sat(d);
               cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, d);
            end
            default: begin
               d = sat(d);
               cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, d);
            end
         endcase
      end
      check_val("drop_saturated", 32'(drop_count), 32'd255);

      // Disable: req ignored, pending cleared, drops kept.
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);

      // 5: re-enable, then abort a pulse at its cycle 2.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd255);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd255);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd255);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);
      for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);
      // Re-enable with req in the disabled cycle (ignored) and in the last guard cycle (consumed).
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255);
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd255);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd255);

      // 6: asynchronous reset mid-guard, between clock edges.
      #2 rst_n = 1'b0;
      #1;
      check_val("async_rst_link", 32'(link_out), 32'd0);
      check_val("async_rst_drop", 32'(drop_count), 32'd0);
      check_val("async_rst_busy", 32'(busy), 32'd1);
      check_val("async_rst_sent", 32'(sent), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check_val("sb_leftover", 32'(sb_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
